// File: rtl/phv_deparser_pkt_gen.sv
// Rebuilds the 134b packet stream from (possibly rewritten) PHV beats plus the buffered original words.
// Optional PHV_DEPARSER_DROP_EN: a drop-tagged first beat discards the whole packet.
module phv_deparser_pkt_gen #(
  parameter int HEAD_WIDTH    = 1024,
  parameter int TAG_WIDTH     = 8,
  parameter int TAG_START_BIT = 0,
  parameter int TAG_TAIL_BIT  = 1,
  parameter int TAG_DROP_BIT  = 2,
  parameter int PKT_FIFO_AW   = 9,
  parameter int PHV_FIFO_AW   = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_pkt_valid,
  input  logic [133:0]                    i_pkt,
  input  logic                            i_phv_valid,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_phv,
  output logic                            o_pkt_valid,
  output logic [133:0]                    o_pkt,
  output logic                            o_err_ovf,
  output logic                            o_err_mis,
  output logic [31:0]                     o_pkt_cnt
);
  localparam int PKT_NUM = HEAD_WIDTH / 128;
  localparam int PHV_W   = HEAD_WIDTH + TAG_WIDTH;
  localparam int WW      = (PKT_NUM > 1) ? $clog2(PKT_NUM) : 1;
  localparam int KA      = PKT_FIFO_AW;
  localparam int HA      = PHV_FIFO_AW;
  localparam int CW      = PKT_FIFO_AW + 1;

  // element 0 is the most significant 128b slice of the beat
  typedef logic [0:PKT_NUM-1][127:0] beat_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EMIT, S_FLUSH, S_DROP} state_e;

  logic [133:0]   pkt_mem_q [1<<KA];
  logic [PHV_W-1:0] phv_mem_q [1<<HA];
  logic [KA:0]    pkt_wp_q, pkt_wp_d, pkt_rp_q, pkt_rp_d;
  logic [HA:0]    phv_wp_q, phv_wp_d, phv_rp_q, phv_rp_d;
  logic           pkt_full, pkt_empty, phv_full, phv_empty;
  logic           pkt_push, phv_push, pkt_pop, phv_pop;
  logic [133:0]   pkt_rd;
  logic [PHV_W-1:0] phv_rd;
  logic           phv_start, phv_tail, word_is_tail;

  state_e         state_q, state_d;
  beat_t          beat_q, beat_d;
  logic           beat_tail_q, beat_tail_d;
  logic [WW-1:0]  w_q, w_d;
  logic           phv_done_q, phv_done_d;
  logic [CW-1:0]  rdy_cnt_q, rdy_cnt_d;
  logic           err_ovf_q, err_ovf_d, err_mis_q, err_mis_d;
  logic [31:0]    pkt_cnt_q, pkt_cnt_d;
  logic [133:0]   o_pkt_q, o_pkt_d;
  logic           emit, last_w, need_next;
  logic [127:0]   out_data;
  logic           unused_tag;
`ifdef PHV_DEPARSER_DROP_EN
  logic           drop_pkt_done_q, drop_pkt_done_d;
  logic           pkt_done_now, phv_done_now;
`endif

  assign pkt_full  = (pkt_wp_q[KA] != pkt_rp_q[KA]) && (pkt_wp_q[KA-1:0] == pkt_rp_q[KA-1:0]);
  assign pkt_empty = (pkt_wp_q == pkt_rp_q);
  assign phv_full  = (phv_wp_q[HA] != phv_rp_q[HA]) && (phv_wp_q[HA-1:0] == phv_rp_q[HA-1:0]);
  assign phv_empty = (phv_wp_q == phv_rp_q);
  assign pkt_push  = i_pkt_valid && !pkt_full;
  assign phv_push  = i_phv_valid && !phv_full;
  assign pkt_rd    = pkt_mem_q[pkt_rp_q[KA-1:0]];
  assign phv_rd    = phv_mem_q[phv_rp_q[HA-1:0]];
  assign phv_start = phv_rd[HEAD_WIDTH+TAG_START_BIT];
  assign phv_tail  = phv_rd[HEAD_WIDTH+TAG_TAIL_BIT];
  assign word_is_tail = pkt_rd[133];
  assign unused_tag   = ^phv_rd[HEAD_WIDTH +: TAG_WIDTH];

  always_ff @(posedge i_clk) begin
    if (pkt_push) pkt_mem_q[pkt_wp_q[KA-1:0]] <= i_pkt;
    if (phv_push) phv_mem_q[phv_wp_q[HA-1:0]] <= i_phv;
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    beat_tail_d = beat_tail_q;
    w_d         = w_q;
    phv_done_d  = phv_done_q;
    err_mis_d   = err_mis_q;
    pkt_cnt_d   = pkt_cnt_q;
    pkt_pop     = 1'b0;
    phv_pop     = 1'b0;
    emit        = 1'b0;
    out_data    = pkt_rd[127:0];
    last_w      = (w_q == WW'(PKT_NUM-1));
    need_next   = !phv_done_q && last_w && !beat_tail_q && !word_is_tail;
`ifdef PHV_DEPARSER_DROP_EN
    drop_pkt_done_d = drop_pkt_done_q;
    pkt_done_now    = 1'b0;
    phv_done_now    = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (rdy_cnt_q != '0 && !phv_empty) state_d = S_LOAD;
      S_LOAD: if (!phv_empty) begin
        phv_pop = 1'b1;
        if (!phv_start) err_mis_d = 1'b1;
        else begin
          beat_d      = phv_rd[HEAD_WIDTH-1:0];
          beat_tail_d = phv_tail;
          w_d         = '0;
          phv_done_d  = 1'b0;
`ifdef PHV_DEPARSER_DROP_EN
          drop_pkt_done_d = 1'b0;
          state_d = phv_rd[HEAD_WIDTH+TAG_DROP_BIT] ? S_DROP : S_EMIT;
`else
          state_d = S_EMIT;
`endif
        end
      end
      S_EMIT: if (!pkt_empty && !(need_next && phv_empty)) begin
        emit    = 1'b1;
        pkt_pop = 1'b1;
        if (!phv_done_q) out_data = beat_q[w_q];
        if (word_is_tail) begin
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          state_d   = (!phv_done_q && !beat_tail_q) ? S_FLUSH : S_IDLE;
        end else if (!phv_done_q) begin
          if (!last_w) w_d = w_q + WW'(1);
          else if (beat_tail_q) begin
            // PHV coverage ran out first: rest of the packet passes through as-is
            phv_done_d = 1'b1;
            err_mis_d  = 1'b1;
          end else begin
            phv_pop     = 1'b1;
            beat_d      = phv_rd[HEAD_WIDTH-1:0];
            beat_tail_d = phv_tail;
            w_d         = '0;
          end
        end
      end
      S_FLUSH: if (!phv_empty) begin
        phv_pop = 1'b1;
        if (phv_tail) begin
          err_mis_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
`ifdef PHV_DEPARSER_DROP_EN
      S_DROP: begin
        // beat_tail_q doubles as "PHV tail already consumed" while dropping
        if (!drop_pkt_done_q && !pkt_empty) pkt_pop = 1'b1;
        if (!beat_tail_q && !phv_empty) phv_pop = 1'b1;
        pkt_done_now    = drop_pkt_done_q || (pkt_pop && word_is_tail);
        phv_done_now    = beat_tail_q || (phv_pop && phv_tail);
        drop_pkt_done_d = pkt_done_now;
        beat_tail_d     = phv_done_now;
        if (pkt_done_now && phv_done_now) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pkt_wp_d  = pkt_wp_q + CW'(pkt_push);
    pkt_rp_d  = pkt_rp_q + CW'(pkt_pop);
    phv_wp_d  = phv_wp_q + (HA+1)'(phv_push);
    phv_rp_d  = phv_rp_q + (HA+1)'(phv_pop);
    rdy_cnt_d = rdy_cnt_q + CW'(pkt_push && i_pkt[133]) - CW'(pkt_pop && word_is_tail);
    err_ovf_d = err_ovf_q || (i_pkt_valid && pkt_full) || (i_phv_valid && phv_full);
  end

  // Output is decoded straight from EMIT so the first word lands two cycles after IDLE fires.
  assign o_pkt_valid = emit;
  assign o_pkt       = emit ? {pkt_rd[133:128], out_data} : o_pkt_q;
  assign o_pkt_d     = o_pkt;
  assign o_err_ovf   = err_ovf_q;
  assign o_err_mis   = err_mis_q;
  assign o_pkt_cnt   = pkt_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_wp_q    <= '0;
      pkt_rp_q    <= '0;
      phv_wp_q    <= '0;
      phv_rp_q    <= '0;
      state_q     <= S_IDLE;
      beat_q      <= '0;
      beat_tail_q <= 1'b0;
      w_q         <= '0;
      phv_done_q  <= 1'b0;
      rdy_cnt_q   <= '0;
      err_ovf_q   <= 1'b0;
      err_mis_q   <= 1'b0;
      pkt_cnt_q   <= '0;
      o_pkt_q     <= '0;
`ifdef PHV_DEPARSER_DROP_EN
      drop_pkt_done_q <= 1'b0;
`endif
    end else begin
      pkt_wp_q    <= pkt_wp_d;
      pkt_rp_q    <= pkt_rp_d;
      phv_wp_q    <= phv_wp_d;
      phv_rp_q    <= phv_rp_d;
      state_q     <= state_d;
      beat_q      <= beat_d;
      beat_tail_q <= beat_tail_d;
      w_q         <= w_d;
      phv_done_q  <= phv_done_d;
      rdy_cnt_q   <= rdy_cnt_d;
      err_ovf_q   <= err_ovf_d;
      err_mis_q   <= err_mis_d;
      pkt_cnt_q   <= pkt_cnt_d;
      o_pkt_q     <= o_pkt_d;
`ifdef PHV_DEPARSER_DROP_EN
      drop_pkt_done_q <= drop_pkt_done_d;
`endif
    end
  end
endmodule

// File: tb/tb_phv_deparser_pkt_gen.sv
// Bench for phv_deparser_pkt_gen: directed table, randomized packets vs. a word-level model, error/reset corners.
module tb_phv_deparser_pkt_gen;
  localparam int HW = 1024, TW = 8, PN = HW / 128, PW = HW + TW;

  logic          i_clk, i_rst_n, i_pkt_valid, i_phv_valid;
  logic [133:0]  i_pkt;
  logic [PW-1:0] i_phv;
  logic          o_pkt_valid, o_err_ovf, o_err_mis;
  logic [133:0]  o_pkt;
  logic [31:0]   o_pkt_cnt;

  phv_deparser_pkt_gen dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pkt_valid(i_pkt_valid), .i_pkt(i_pkt),
    .i_phv_valid(i_phv_valid), .i_phv(i_phv), .o_pkt_valid(o_pkt_valid), .o_pkt(o_pkt),
    .o_err_ovf(o_err_ovf), .o_err_mis(o_err_mis), .o_pkt_cnt(o_pkt_cnt));

  typedef struct { int len; int nb; logic [3:0] vb; logic [127:0] seed; bit mis; } vec_t;
  vec_t tbl[5];

  logic [133:0] pw[64];
  logic [127:0] sl[8][PN];
  logic [133:0] got_q[$];
  int           got_cyc[$];
  int           cyc = 0;
  int           nvec, nerr, c0;
  logic         mis_m;
  logic [31:0]  cnt_m;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) if (o_pkt_valid) begin
    got_q.push_back(o_pkt);
    got_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge i_clk); #1;
  endtask

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Original words get tags 01/00../10 (11 when single), valid bytes only on the last word.
  task automatic build(input int len, input int nb, input logic [3:0] vb, input logic [127:0] seed, input bit rnd);
    for (int i = 0; i < len; i++) begin
      logic [1:0] tg;
      tg = (len == 1) ? 2'b11 : (i == 0) ? 2'b01 : (i == len-1) ? 2'b10 : 2'b00;
      pw[i] = {tg, (i == len-1) ? vb : 4'd0,
               rnd ? {$urandom(), $urandom(), $urandom(), $urandom()} : 128'hD000 + 128'(i)};
    end
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < PN; k++)
        sl[b][k] = rnd ? {$urandom(), $urandom(), $urandom(), $urandom()} : seed + 128'(8*b + k);
  endtask

  task automatic send(input int len, input int nb, input bit drop, input int maxgap, output int t0);
    t0 = 0;
    for (int i = 0; i < len; i++) begin
      i_pkt_valid = 1'b1; i_pkt = pw[i]; tick;
    end
    i_pkt_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      logic [PW-1:0] bt;
      repeat ($urandom_range(0, maxgap)) tick;
      bt = '0;
      for (int k = 0; k < PN; k++) bt[HW-1-128*k -: 128] = sl[b][k];
      bt[HW+0] = (b == 0);
      bt[HW+1] = (b == nb-1);
      bt[HW+2] = drop && (b == 0);
      i_phv_valid = 1'b1; i_phv = bt; tick;
      i_phv_valid = 1'b0;
      if (b == 0) t0 = cyc;
    end
  endtask

  // Word i comes from beat i/8 slice i%8 while beats last, otherwise the original word.
  task automatic expect_pkt(input string nm, input int len, input int nb);
    int t = 0;
    while (got_q.size() < len && t < 400) begin tick; t++; end
    repeat (6) tick;
    chk({nm, " count"}, 134'(got_q.size()), 134'(len));
    for (int i = 0; i < len && i < got_q.size(); i++) begin
      logic [127:0] d;
      d = (i / 8 < nb) ? sl[i/8][i%8] : pw[i][127:0];
      chk($sformatf("%s w%0d", nm, i), got_q[i], {pw[i][133:128], d});
    end
    chk({nm, " cnt"}, 134'(o_pkt_cnt), 134'(cnt_m));
    chk({nm, " mis"}, 134'(o_err_mis), 134'(mis_m));
  endtask

  initial begin
    nvec = 0; nerr = 0; mis_m = 1'b0; cnt_m = '0;
    i_rst_n = 1'b0; i_pkt_valid = 1'b0; i_phv_valid = 1'b0; i_pkt = '0; i_phv = '0;
    tbl[0] = '{4,  1, 4'd0, 128'hA0,  1'b0};
    tbl[1] = '{11, 2, 4'd7, 128'hB00, 1'b0};
    tbl[2] = '{1,  1, 4'd4, 128'hC00, 1'b0};
    tbl[3] = '{10, 1, 4'd0, 128'hE00, 1'b1};
    tbl[4] = '{1,  2, 4'd9, 128'hF00, 1'b1};

    repeat (3) tick;
    chk("rst valid", 134'(o_pkt_valid), 134'd0);
    chk("rst pkt",   o_pkt,             134'd0);
    chk("rst cnt",   134'(o_pkt_cnt),   134'd0);
    chk("rst ovf",   134'(o_err_ovf),   134'd0);
    chk("rst mis",   134'(o_err_mis),   134'd0);
    @(negedge i_clk); i_rst_n = 1'b1;
    tick;

    for (int r = 0; r < 5; r++) begin
      build(tbl[r].len, tbl[r].nb, tbl[r].vb, tbl[r].seed, 1'b0);
      got_q.delete(); got_cyc.delete();
      send(tbl[r].len, tbl[r].nb, 1'b0, 0, c0);
      mis_m = mis_m | tbl[r].mis;
      cnt_m = cnt_m + 32'd1;
      expect_pkt($sformatf("tbl%0d", r), tbl[r].len, tbl[r].nb);
      if (got_cyc.size() > 0) chk($sformatf("tbl%0d latency", r), 134'(got_cyc[0] - c0), 134'd2);
      if (r == 1 && got_cyc.size() > 8) chk("tbl1 no bubble", 134'(got_cyc[8] - got_cyc[7]), 134'd1);
    end

    for (int n = 0; n < 30; n++) begin
      int len, nb;
      len = $urandom_range(1, 24);
      nb  = (len + 7) / 8;
      build(len, nb, 4'($urandom_range(0, 15)), '0, 1'b1);
      got_q.delete(); got_cyc.delete();
      send(len, nb, 1'b0, 3, c0);
      cnt_m = cnt_m + 32'd1;
      expect_pkt($sformatf("rnd%0d", n), len, nb);
    end

`ifdef PHV_DEPARSER_DROP_EN
    build(12, 2, 4'd3, 128'h5500, 1'b0);
    got_q.delete();
    send(12, 2, 1'b1, 2, c0);
    repeat (30) tick;
    chk("drop no words", 134'(got_q.size()), 134'd0);
    chk("drop cnt", 134'(o_pkt_cnt), 134'(cnt_m));
    build(3, 1, 4'd2, 128'h6600, 1'b0);
    got_q.delete();
    send(3, 1, 1'b0, 0, c0);
    cnt_m = cnt_m + 32'd1;
    expect_pkt("after drop", 3, 1);
`else
    build(5, 1, 4'd1, 128'h7700, 1'b0);
    got_q.delete();
    send(5, 1, 1'b1, 0, c0);
    cnt_m = cnt_m + 32'd1;
    expect_pkt("drop ignored", 5, 1);
`endif

    for (int i = 0; i < 16; i++) begin
      i_phv_valid = 1'b1; i_phv = '0; tick;
    end
    chk("ovf at full", 134'(o_err_ovf), 134'd0);
    tick;
    i_phv_valid = 1'b0;
    chk("ovf set", 134'(o_err_ovf), 134'd1);
    i_rst_n = 1'b0; #1;
    chk("rst2 ovf", 134'(o_err_ovf), 134'd0);
    chk("rst2 cnt", 134'(o_pkt_cnt), 134'd0);
    tick; tick;
    @(negedge i_clk); i_rst_n = 1'b1;
    cnt_m = '0; mis_m = 1'b0;

    build(20, 3, 4'd0, '0, 1'b1);
    got_q.delete();
    send(20, 3, 1'b0, 0, c0);
    for (int t = 0; t < 100 && got_q.size() < 3; t++) tick;
    chk("pre-rst emitting", 134'(o_pkt_valid), 134'd1);
    i_rst_n = 1'b0; #1;
    chk("midrst valid", 134'(o_pkt_valid), 134'd0);
    chk("midrst pkt",   o_pkt,             134'd0);
    chk("midrst cnt",   134'(o_pkt_cnt),   134'd0);
    chk("midrst mis",   134'(o_err_mis),   134'd0);
    tick; tick;
    @(negedge i_clk); i_rst_n = 1'b1;
    tick;

    build(9, 2, 4'd5, '0, 1'b1);
    got_q.delete();
    send(9, 2, 1'b0, 1, c0);
    cnt_m = 32'd1;
    expect_pkt("post rst", 9, 2);
    chk("post rst ovf", 134'(o_err_ovf), 134'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
